// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding UART_TX: buffers producer writes and launches one frame
// at a time, waiting for the transmitter's end-of-frame before the next.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic             i_Wr_DV,
  input  logic [7:0]       i_Wr_Byte,
  output logic             o_Full,
  output logic             o_Empty,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Overflow,
  output logic             o_TX_DV,
  output logic [7:0]       o_TX_Byte,
  input  logic             i_TX_Active,
  input  logic             i_TX_Done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACT,
    WAIT_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             txDv_q, txDv_d;
  logic [7:0]       txByte_q, txByte_d;
  logic [7:0]       mem [DEPTH];

  logic full, empty, pop, wrAccept;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign wrAccept = i_Wr_DV && (!full || pop);

  always_ff @(posedge i_Clock) begin
    if (wrAccept) begin
      mem[wrPtr_q] <= i_Wr_Byte;
    end
  end

  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    txDv_d     = 1'b0;
    txByte_d   = txByte_q;

    if (wrAccept) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end

    case ({wrAccept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (i_Wr_DV && !wrAccept) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          txByte_d = mem[rdPtr_q];
          txDv_d   = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_ACT;
      end
      WAIT_ACT: begin
        // A done seen before active means a frame too short to observe busy.
        if (i_TX_Done) begin
          state_d = IDLE;
        end else if (i_TX_Active) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_TX_Done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      txDv_q     <= 1'b0;
      txByte_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      txDv_q     <= txDv_d;
      txByte_q   <= txByte_d;
    end
  end

  assign o_Full     = full;
  assign o_Empty    = empty;
  assign o_Count    = count_q;
  assign o_Overflow = overflow_q;
  assign o_TX_DV    = txDv_q;
  assign o_TX_Byte  = txByte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART_TX responder that
// raises active for a fixed frame length and then pulses done.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int FRAME = 40;

  logic       clk = 1'b0;
  logic       rstL;
  logic       wrDv;
  logic [7:0] wrByte;
  logic       txActive;
  logic       txDone;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       txDv;
  logic [7:0] txByte;

  int passCount    = 0;
  int checkCount   = 0;
  int tickNum      = 0;
  int lastDoneTick = -100;
  int dvCount      = 0;
  int dvWhileBusy  = 0;
  logic [7:0] launched [$];

  always #20 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock    (clk),
    .i_Rst_L    (rstL),
    .i_Wr_DV    (wrDv),
    .i_Wr_Byte  (wrByte),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Count    (count),
    .o_Overflow (overflow),
    .o_TX_DV    (txDv),
    .o_TX_Byte  (txByte),
    .i_TX_Active(txActive),
    .i_TX_Done  (txDone)
  );

  // Transmitter model: reacts on the falling edge, aborts its frame on reset.
  initial begin
    txActive = 1'b0;
    txDone   = 1'b0;
    forever begin
      @(negedge clk);
      if (rstL !== 1'b1) begin
        txActive = 1'b0;
        txDone   = 1'b0;
      end else if (txDv === 1'b1) begin
        launched.push_back(txByte);
        dvCount++;
        txActive = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
          @(negedge clk);
          if (rstL !== 1'b1) break;
        end
        txActive = 1'b0;
        if (rstL === 1'b1) begin
          txDone = 1'b1;
          @(negedge clk);
          txDone = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #5;
    tickNum++;
    if (txDone === 1'b1) lastDoneTick = tickNum;
    if (txDv === 1'b1 && txActive === 1'b1) dvWhileBusy++;
  endtask

  task automatic applyStimulus(input logic rst, input logic dv, input logic [7:0] b);
    rstL   = rst;
    wrDv   = dv;
    wrByte = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic waitDv(input string tag, output int gap);
    int found = 0;
    gap = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (txDv === 1'b1) begin
        found = 1;
        gap   = tickNum - lastDoneTick;
        break;
      end
    end
    if (found == 0) checkOutput({tag, "_timeout"}, 32'(found), 32'd1);
  endtask

  task automatic waitDone(input string tag);
    int found = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (txDone === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (found == 0) checkOutput({tag, "_timeout"}, 32'(found), 32'd1);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b0, 8'h00);
    launched.delete();
    dvCount = 0;
    tick();
  endtask

  initial begin
    int gap;
    logic [7:0] burst [3];
    burst[0] = 8'hA1;
    burst[1] = 8'hB2;
    burst[2] = 8'hC3;

    // Reset state
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_txdv", 32'(txDv), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_txbyte", 32'(txByte), 32'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick();

    // Single byte: stored at the write edge, launched one edge later
    applyStimulus(1'b1, 1'b1, 8'h3F);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("single_count_stored", 32'(count), 32'd1);
    checkOutput("single_empty_stored", 32'(empty), 32'd0);
    checkOutput("single_no_bypass", 32'(txDv), 32'd0);
    tick();
    checkOutput("single_dv", 32'(txDv), 32'd1);
    checkOutput("single_byte", 32'(txByte), 32'h3F);
    checkOutput("single_empty_after_pop", 32'(empty), 32'd1);
    tick();
    checkOutput("single_dv_one_cycle", 32'(txDv), 32'd0);
    checkOutput("single_byte_hold", 32'(txByte), 32'h3F);
    waitDone("single_done");
    repeat (3) tick();

    // Burst of three: each later launch follows the previous done
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, burst[i]);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("burst_count", 32'(count), 32'd2);
    for (int i = 1; i < 3; i++) begin
      waitDv("burst_dv", gap);
      checkOutput("burst_gap_after_done", 32'(gap), 32'd1);
      checkOutput("burst_byte", 32'(txByte), 32'(burst[i]));
    end
    waitDone("burst_done");
    repeat (3) tick();
    checkOutput("burst_dv_count", 32'(dvCount), 32'd4);
    checkOutput("burst_order0", 32'(launched[1]), 32'hA1);
    checkOutput("burst_order1", 32'(launched[2]), 32'hB2);
    checkOutput("burst_order2", 32'(launched[3]), 32'hC3);

    // Overflow while a frame is in progress
    resetDut();
    applyStimulus(1'b1, 1'b1, 8'h0F);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00);
    waitDv("ovf_first_dv", gap);
    repeat (3) tick();
    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h10 + i));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("ovf_full", 32'(full), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd16);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i <= DEPTH; i++) waitDone("ovf_drain");
    repeat (5) tick();
    checkOutput("ovf_dv_count", 32'(dvCount), 32'd17);
    checkOutput("ovf_last_sent", 32'(launched[launched.size() - 1]), 32'h1F);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    checkOutput("ovf_drained_empty", 32'(empty), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("ovf_order", 32'(launched[i + 1]), 32'(8'h10 + i));
    end

    // Full FIFO with a write on the same edge as the pop
    resetDut();
    applyStimulus(1'b1, 1'b1, 8'h0F);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00);
    waitDv("fullpop_first_dv", gap);
    repeat (3) tick();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h30 + i));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("fullpop_full_before", 32'(full), 32'd1);
    checkOutput("fullpop_ovf_before", 32'(overflow), 32'd0);
    waitDone("fullpop_done");
    applyStimulus(1'b1, 1'b1, 8'hEE);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("fullpop_dv", 32'(txDv), 32'd1);
    checkOutput("fullpop_byte", 32'(txByte), 32'h30);
    checkOutput("fullpop_count", 32'(count), 32'd16);
    checkOutput("fullpop_full", 32'(full), 32'd1);
    checkOutput("fullpop_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i <= DEPTH; i++) waitDone("fullpop_drain");
    repeat (5) tick();
    checkOutput("fullpop_dv_count", 32'(dvCount), 32'd18);
    checkOutput("fullpop_last_sent", 32'(launched[launched.size() - 1]), 32'hEE);

    // Reset during the second of four frames
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h61 + i));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 300 && dvCount < 2; i++) tick();
    checkOutput("midrst_second_launch", 32'(dvCount), 32'd2);
    repeat (5) tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    checkOutput("midrst_txdv", 32'(txDv), 32'd0);
    repeat (60) tick();
    checkOutput("midrst_no_more_dv", 32'(dvCount), 32'd2);
    applyStimulus(1'b1, 1'b1, 8'h55);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("midrst_new_dv", 32'(txDv), 32'd1);
    checkOutput("midrst_new_byte", 32'(txByte), 32'h55);
    waitDone("midrst_done");
    repeat (3) tick();
    checkOutput("midrst_dv_count", 32'(dvCount), 32'd3);
    checkOutput("midrst_last_sent", 32'(launched[launched.size() - 1]), 32'h55);
    checkOutput("dv_while_busy", 32'(dvWhileBusy), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
